// File: rtl/key_voice_allocator.sv
// Polyphonic voice allocator: PS/2 key events -> per-voice note frequency and linear attack/release volume.
// Define SUSTAIN_PEDAL_EN to turn the space bar (scancode 29) into a sustain pedal.
module key_voice_allocator #(
  parameter int               VOICES       = 4,
  parameter int               FREQ_W       = 16,
  parameter int               VOL_W        = 20,
  parameter logic [VOL_W-1:0] VOL_MAX      = 20'h80000,
  parameter logic [VOL_W-1:0] ATTACK_STEP  = 20'h04000,
  parameter logic [VOL_W-1:0] RELEASE_STEP = 20'h01000,
  parameter int               TICK_DIV     = 24000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  output logic [VOICES*FREQ_W-1:0] frequencies,
  output logic [VOICES*VOL_W-1:0]  voice_volumes,
  output logic [VOICES-1:0]        voice_active,
  output logic [2:0]               octave,
  output logic                     key_event
);

  localparam int         PTR_W     = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int         PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;
`ifdef SUSTAIN_PEDAL_EN
  localparam logic [7:0] SC_PEDAL  = 8'h29;
`endif

  typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;

  voice_state_t      state   [VOICES];
  voice_state_t      state_n [VOICES];
  logic [7:0]        code    [VOICES];
  logic [7:0]        code_n  [VOICES];
  logic [VOL_W-1:0]  vol     [VOICES];
  logic [VOL_W-1:0]  vol_n   [VOICES];
  logic [FREQ_W-1:0] freq    [VOICES];
  logic [FREQ_W-1:0] freq_n  [VOICES];
  logic [PTR_W-1:0]  steal_ptr, steal_ptr_n;
  logic [2:0]        octave_n;
  logic              key_event_n;
  logic              prev_toggle;
  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  logic [VOICES-1:0] touched;
`ifdef SUSTAIN_PEDAL_EN
  logic              pedal, pedal_n;
  logic [VOICES-1:0] pending, pending_n;
`endif

  logic              ev, pressed;
  logic [7:0]        sc;
  logic [9:0]        base;
  logic [13:0]       shifted;
  logic [FREQ_W-1:0] note_freq;
  logic              held, rel_found, idle_found;
  logic [PTR_W-1:0]  rel_idx, idle_idx, target;
  logic [VOL_W:0]    att_sum;

  assign ev      = (ps2_key[10] != prev_toggle) && !ps2_key[8];
  assign pressed = ps2_key[9];
  assign sc      = ps2_key[7:0];
  assign tick    = (prescaler == PRE_W'(TICK_DIV - 1));

  always_comb begin
    case (sc)
      8'h1C:   base = 10'd262;
      8'h1D:   base = 10'd277;
      8'h1B:   base = 10'd294;
      8'h24:   base = 10'd311;
      8'h23:   base = 10'd330;
      8'h2B:   base = 10'd349;
      8'h2C:   base = 10'd370;
      8'h34:   base = 10'd392;
      8'h35:   base = 10'd415;
      8'h33:   base = 10'd440;
      8'h3C:   base = 10'd466;
      8'h3B:   base = 10'd494;
      8'h42:   base = 10'd523;
      default: base = 10'd0;
    endcase
    shifted   = {4'b0, base} << octave;
    note_freq = FREQ_W'(shifted >> 2);
  end

  always_comb begin
    state_n     = state;
    code_n      = code;
    vol_n       = vol;
    freq_n      = freq;
    steal_ptr_n = steal_ptr;
    octave_n    = octave;
    key_event_n = 1'b0;
    touched     = '0;
    held        = 1'b0;
    rel_found   = 1'b0;
    idle_found  = 1'b0;
    rel_idx     = '0;
    idle_idx    = '0;
    target      = '0;
    att_sum     = '0;
`ifdef SUSTAIN_PEDAL_EN
    pedal_n     = pedal;
    pending_n   = pending;
`endif

    for (int i = 0; i < VOICES; i++) begin
      if ((state[i] == V_ATTACK || state[i] == V_SUSTAIN) && code[i] == sc) held = 1'b1;
      if (!rel_found && state[i] == V_RELEASE && code[i] == sc) begin
        rel_found = 1'b1;
        rel_idx   = PTR_W'(i);
      end
      if (!idle_found && state[i] == V_IDLE) begin
        idle_found = 1'b1;
        idle_idx   = PTR_W'(i);
      end
    end

    if (ev) begin
      if (pressed && sc == SC_OCT_DN) begin
        if (octave != 3'd0) octave_n = octave - 3'd1;
      end else if (pressed && sc == SC_OCT_UP) begin
        if (octave < 3'd4) octave_n = octave + 3'd1;
`ifdef SUSTAIN_PEDAL_EN
      end else if (sc == SC_PEDAL) begin
        pedal_n = pressed;
        if (!pressed && pedal) begin
          for (int i = 0; i < VOICES; i++) begin
            if (pending[i]) begin
              pending_n[i] = 1'b0;
              state_n[i]   = V_RELEASE;
              touched[i]   = 1'b1;
            end
          end
        end
`endif
      end else if (base != 10'd0 && pressed) begin
        if (held) begin
`ifdef SUSTAIN_PEDAL_EN
          // A key struck again under the pedal is physically held once more.
          for (int i = 0; i < VOICES; i++) begin
            if ((state[i] == V_ATTACK || state[i] == V_SUSTAIN) && code[i] == sc) pending_n[i] = 1'b0;
          end
`endif
        end else if (rel_found) begin
          state_n[rel_idx] = V_ATTACK;
          touched[rel_idx] = 1'b1;
          key_event_n      = 1'b1;
        end else begin
          target = idle_found ? idle_idx : steal_ptr;
          if (!idle_found) begin
            steal_ptr_n = (steal_ptr == PTR_W'(VOICES - 1)) ? '0 : steal_ptr + PTR_W'(1);
          end
          state_n[target] = V_ATTACK;
          vol_n[target]   = '0;
          freq_n[target]  = note_freq;
          code_n[target]  = sc;
          touched[target] = 1'b1;
          key_event_n     = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
          pending_n[target] = 1'b0;
`endif
        end
      end else if (base != 10'd0) begin
        for (int i = 0; i < VOICES; i++) begin
          if ((state[i] == V_ATTACK || state[i] == V_SUSTAIN) && code[i] == sc) begin
`ifdef SUSTAIN_PEDAL_EN
            if (pedal) pending_n[i] = 1'b1;
            else       state_n[i]   = V_RELEASE;
`else
            state_n[i] = V_RELEASE;
`endif
            touched[i]  = 1'b1;
            key_event_n = 1'b1;
          end
        end
      end
    end

    // Envelope step; a voice touched by this cycle's key event skips the tick.
    if (tick) begin
      for (int i = 0; i < VOICES; i++) begin
        if (!touched[i]) begin
          case (state[i])
            V_ATTACK: begin
              att_sum = {1'b0, vol[i]} + {1'b0, ATTACK_STEP};
              if (att_sum >= {1'b0, VOL_MAX}) begin
                vol_n[i]   = VOL_MAX;
                state_n[i] = V_SUSTAIN;
              end else begin
                vol_n[i] = att_sum[VOL_W-1:0];
              end
            end
            V_RELEASE: begin
              if (vol[i] <= RELEASE_STEP) begin
                vol_n[i]   = '0;
                freq_n[i]  = '0;
                state_n[i] = V_IDLE;
              end else begin
                vol_n[i] = vol[i] - RELEASE_STEP;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    prev_toggle <= ps2_key[10];
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        state[i] <= V_IDLE;
        code[i]  <= '0;
        vol[i]   <= '0;
        freq[i]  <= '0;
      end
      steal_ptr <= '0;
      octave    <= 3'd2;
      key_event <= 1'b0;
      prescaler <= '0;
`ifdef SUSTAIN_PEDAL_EN
      pedal     <= 1'b0;
      pending   <= '0;
`endif
    end else begin
      state     <= state_n;
      code      <= code_n;
      vol       <= vol_n;
      freq      <= freq_n;
      steal_ptr <= steal_ptr_n;
      octave    <= octave_n;
      key_event <= key_event_n;
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
`ifdef SUSTAIN_PEDAL_EN
      pedal     <= pedal_n;
      pending   <= pending_n;
`endif
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign frequencies[g*FREQ_W +: FREQ_W]  = freq[g];
    assign voice_volumes[g*VOL_W +: VOL_W]  = vol[g];
    assign voice_active[g]                  = (state[g] != V_IDLE);
  end

endmodule

// File: tb/tb_key_voice_allocator.sv
// Scoreboard bench for key_voice_allocator: a behavioural voice model predicts every key_event snapshot.
// Uses a short envelope tick so full attack/release cycles stay cheap.
module tb_key_voice_allocator;

  localparam int VOICES       = 4;
  localparam int FREQ_W       = 16;
  localparam int VOL_W        = 20;
  localparam int TICK_DIV     = 16;
  localparam int VOL_MAX      = 'h80000;
  localparam int ATTACK_STEP  = 'h04000;
  localparam int RELEASE_STEP = 'h01000;

  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_SUS  = 2;
  localparam int M_REL  = 3;

  logic                     clk_sys;
  logic                     reset;
  logic [10:0]              ps2_key;
  logic [VOICES*FREQ_W-1:0] frequencies;
  logic [VOICES*VOL_W-1:0]  voice_volumes;
  logic [VOICES-1:0]        voice_active;
  logic [2:0]               octave;
  logic                     key_event;

  key_voice_allocator #(
    .VOICES(VOICES), .FREQ_W(FREQ_W), .VOL_W(VOL_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .frequencies(frequencies), .voice_volumes(voice_volumes),
    .voice_active(voice_active), .octave(octave), .key_event(key_event)
  );

  typedef struct packed {
    logic [63:0]              due;
    logic [VOICES*FREQ_W-1:0] f;
    logic [VOICES*VOL_W-1:0]  v;
    logic [VOICES-1:0]        a;
    logic [2:0]               o;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failures = 0;

  int m_st[VOICES];
  int m_code[VOICES];
  int m_vol[VOICES];
  int m_freq[VOICES];
  int m_oct, m_ptr, m_pre;
  int note_hz[int];

  logic [7:0] rand_keys [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                 8'h33, 8'h42, 8'h1A, 8'h22, 8'h29, 8'h12};

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic void compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [VOICES*FREQ_W-1:0] exp_freq();
    logic [VOICES*FREQ_W-1:0] r = '0;
    for (int i = 0; i < VOICES; i++) r[i*FREQ_W +: FREQ_W] = FREQ_W'(m_freq[i]);
    return r;
  endfunction

  function automatic logic [VOICES*VOL_W-1:0] exp_vol();
    logic [VOICES*VOL_W-1:0] r = '0;
    for (int i = 0; i < VOICES; i++) r[i*VOL_W +: VOL_W] = VOL_W'(m_vol[i]);
    return r;
  endfunction

  function automatic logic [VOICES-1:0] exp_active();
    logic [VOICES-1:0] r = '0;
    for (int i = 0; i < VOICES; i++) r[i] = (m_st[i] != M_IDLE);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_st[i] = M_IDLE; m_code[i] = 0; m_vol[i] = 0; m_freq[i] = 0;
    end
    m_oct = 2; m_ptr = 0; m_pre = 0;
  endfunction

  // Predicts the voice bank after the coming rising edge.
  function automatic void model_cycle(input bit ev, input bit press, input logic [7:0] sc);
    bit   tick, accepted, held;
    bit   busy[VOICES];
    int   k, v;
    exp_t e;
    k = int'(sc);
    tick = (m_pre == TICK_DIV - 1);
    m_pre = tick ? 0 : m_pre + 1;
    accepted = 1'b0;
    for (int i = 0; i < VOICES; i++) busy[i] = 1'b0;
    if (ev) begin
      if (press && k == 'h1A) begin
        if (m_oct > 0) m_oct--;
      end else if (press && k == 'h22) begin
        if (m_oct < 4) m_oct++;
      end else if (note_hz.exists(k)) begin
        if (press) begin
          held = 1'b0;
          for (int i = 0; i < VOICES; i++)
            if ((m_st[i] == M_ATK || m_st[i] == M_SUS) && m_code[i] == k) held = 1'b1;
          if (!held) begin
            v = -1;
            for (int i = 0; i < VOICES; i++)
              if (v < 0 && m_st[i] == M_REL && m_code[i] == k) v = i;
            if (v >= 0) begin
              m_st[v] = M_ATK;
            end else begin
              for (int i = 0; i < VOICES; i++)
                if (v < 0 && m_st[i] == M_IDLE) v = i;
              if (v < 0) begin
                v = m_ptr;
                m_ptr = (m_ptr + 1) % VOICES;
              end
              m_st[v] = M_ATK; m_vol[v] = 0; m_code[v] = k;
              m_freq[v] = note_hz[k] * (2 ** m_oct) / 4;
            end
            busy[v] = 1'b1;
            accepted = 1'b1;
          end
        end else begin
          for (int i = 0; i < VOICES; i++) begin
            if ((m_st[i] == M_ATK || m_st[i] == M_SUS) && m_code[i] == k) begin
              m_st[i] = M_REL; busy[i] = 1'b1; accepted = 1'b1;
            end
          end
        end
      end
    end
    if (tick) begin
      for (int i = 0; i < VOICES; i++) begin
        if (!busy[i] && m_st[i] == M_ATK) begin
          m_vol[i] = m_vol[i] + ATTACK_STEP;
          if (m_vol[i] >= VOL_MAX) begin
            m_vol[i] = VOL_MAX; m_st[i] = M_SUS;
          end
        end else if (!busy[i] && m_st[i] == M_REL) begin
          if (m_vol[i] <= RELEASE_STEP) begin
            m_vol[i] = 0; m_freq[i] = 0; m_st[i] = M_IDLE;
          end else begin
            m_vol[i] = m_vol[i] - RELEASE_STEP;
          end
        end
      end
    end
    if (accepted) begin
      e.due = 64'($time) + 64'd6;
      e.f = exp_freq(); e.v = exp_vol(); e.a = exp_active(); e.o = 3'(m_oct);
      exp_q.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input bit ev, input bit press, input bit ext, input logic [7:0] sc);
    @(negedge clk_sys);
    if (ev) ps2_key = {~ps2_key[10], press, ext, sc};
    model_cycle(ev && !ext, press, sc);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk_sys);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  task automatic key(input logic [7:0] sc, input bit press);
    applyStimulus(1'b1, press, 1'b0, sc);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkOutput(input string name);
    compare({name, " frequencies"}, 128'(frequencies), 128'(exp_freq()));
    compare({name, " volumes"}, 128'(voice_volumes), 128'(exp_vol()));
    compare({name, " active"}, 128'(voice_active), 128'(exp_active()));
    compare({name, " octave"}, 128'(octave), 128'(m_oct));
  endtask

  // Monitor: every key_event pulse must match the oldest predicted snapshot, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == 64'($time)) begin
        e = exp_q.pop_front();
        compare("sb key_event", 128'(key_event), 128'(1));
        compare("sb frequencies", 128'(frequencies), 128'(e.f));
        compare("sb volumes", 128'(voice_volumes), 128'(e.v));
        compare("sb active", 128'(voice_active), 128'(e.a));
        compare("sb octave", 128'(octave), 128'(e.o));
      end else if (key_event) begin
        compare("sb unexpected key_event", 128'(key_event), 128'(0));
      end
    end
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned gap;
    reset   = 1'b1;
    ps2_key = '0;
    note_hz['h1C] = 262; note_hz['h1D] = 277; note_hz['h1B] = 294; note_hz['h24] = 311;
    note_hz['h23] = 330; note_hz['h2B] = 349; note_hz['h2C] = 370; note_hz['h34] = 392;
    note_hz['h35] = 415; note_hz['h33] = 440; note_hz['h3C] = 466; note_hz['h3B] = 494;
    note_hz['h42] = 523;
    model_reset();

    applyReset();
    checkOutput("reset");
    compare("reset octave", 128'(octave), 128'(2));
    compare("reset key_event", 128'(key_event), 128'(0));

    key(8'h1C, 1'b1);
    compare("press 1C key_event", 128'(key_event), 128'(1));
    compare("press 1C freq0", 128'(frequencies[FREQ_W-1:0]), 128'(262));
    wait_ticks(33);
    compare("attack vol0", 128'(voice_volumes[VOL_W-1:0]), 128'('h80000));
    checkOutput("after attack");

    key(8'h1C, 1'b1);
    compare("typematic key_event", 128'(key_event), 128'(0));
    compare("typematic active", 128'(voice_active), 128'(4'b0001));

    key(8'h1D, 1'b1); key(8'h1B, 1'b1); key(8'h24, 1'b1); key(8'h23, 1'b1);
    compare("steal freq0", 128'(frequencies[FREQ_W-1:0]), 128'(330));
    compare("steal vol0", 128'(voice_volumes[VOL_W-1:0]), 128'(0));
    checkOutput("steal");

    key(8'h1C, 1'b0); key(8'h1D, 1'b0); key(8'h1B, 1'b0); key(8'h24, 1'b0); key(8'h23, 1'b0);
    wait_ticks(140);
    compare("all released active", 128'(voice_active), 128'(0));

    key(8'h22, 1'b1); key(8'h22, 1'b1);
    compare("octave up", 128'(octave), 128'(4));
    key(8'h33, 1'b1);
    compare("octave4 freq0", 128'(frequencies[FREQ_W-1:0]), 128'(1760));
    key(8'h33, 1'b0);
    wait_ticks(140);
    repeat (5) key(8'h1A, 1'b1);
    compare("octave down", 128'(octave), 128'(0));
    key(8'h33, 1'b1);
    compare("octave0 freq0", 128'(frequencies[FREQ_W-1:0]), 128'(110));

    wait_ticks(33);
    key(8'h33, 1'b0);
    checkOutput("release from sustain");
    wait_ticks(60);
    key(8'h33, 1'b1);
    compare("re-press key_event", 128'(key_event), 128'(1));
    checkOutput("re-press mid release");
    wait_ticks(33);
    key(8'h33, 1'b0);
    wait_ticks(127);
    checkOutput("late release");
    wait_ticks(2);
    compare("released freq0", 128'(frequencies[FREQ_W-1:0]), 128'(0));
    compare("released vol0", 128'(voice_volumes[VOL_W-1:0]), 128'(0));
    compare("released active", 128'(voice_active), 128'(0));

    for (int n = 0; n < 250; n++) begin
      applyStimulus(1'b1, ($urandom_range(0, 99) < 55), ($urandom_range(0, 15) == 0),
                    rand_keys[$urandom_range(0, 11)]);
      gap = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 20) : $urandom_range(50, 400);
      repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      if (n % 25 == 24) checkOutput("random");
      if (n == 125) begin
        applyReset();
        checkOutput("mid-run reset");
      end
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    compare("scoreboard drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
